// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// functs, ALU codes, datapath mux selects and the bundled control word.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_LW_WB   = 4'd4,
      S_MEM_WR  = 4'd5,
      S_R_EX    = 4'd6,
      S_R_WB    = 4'd7,
      S_BR      = 4'd8,
      S_J       = 4'd9,
      S_JAL     = 4'd10,
      S_I_EX    = 4'd11,
      S_I_WB    = 4'd12,
      S_LUI_WB  = 4'd13,
      S_JR      = 4'd14
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_LUI    = 2'b10;
   localparam logic [1:0] WB_PC     = 2'b11;

   localparam logic SRCA_PC   = 1'b0;
   localparam logic SRCA_RS   = 1'b1;
   localparam logic ADDR_PC   = 1'b0;
   localparam logic ADDR_ALUO = 1'b1;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_sel;
      logic [2:0] alu_control;
      logic [1:0] data_to_reg;
      logic       reg_dst;
      logic       jal;
      logic       reg_write;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t ctrl_default();
      ctrl_t c;
      c             = '0;
      c.alu_control = ALU_ADD;
      c.ext_sel     = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       MemRead;
   logic       MemWrite;
   logic       IorD;
   logic       IRWrite;
   logic       PCWrite;
   logic [1:0] PCSource;
   logic       ALUSrcA;
   logic [1:0] ALUSrc_B;
   logic       ExtSel;
   logic [2:0] ALU_Control;
   logic [1:0] DatatoReg;
   logic       RegDst;
   logic       Jal;
   logic       RegWrite;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
             ALUSrc_B, ExtSel, ALU_Control, DatatoReg, RegDst, Jal, RegWrite,
             illegal, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
             ALUSrc_B, ExtSel, ALU_Control, DatatoReg, RegDst, Jal, RegWrite,
             illegal, state
   );
endinterface

// File: rtl/mc_ctrl_fsm_alu_op_decoder.sv
// ALU operation / immediate-extension decode for the execute-type states;
// flags an R-type funct the datapath cannot execute.
module alu_op_decoder
   import mc_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       ext_sel,
   output logic       illegal_funct
);

   // State-qualified ALU op selection; add/sign-extend everywhere else.
   always_comb begin
      alu_control   = ALU_ADD;
      ext_sel       = 1'b1;
      illegal_funct = 1'b0;
      case (state)
         S_R_EX: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_XOR:  alu_control = ALU_XOR;
               FN_NOR:  alu_control = ALU_NOR;
               FN_SLT:  alu_control = ALU_SLT;
               FN_SRL:  alu_control = ALU_SRL;
               default: illegal_funct = 1'b1;
            endcase
         end
         S_I_EX: begin
            case (opcode)
               OP_ANDI: begin alu_control = ALU_AND; ext_sel = 1'b0; end
               OP_ORI:  begin alu_control = ALU_OR;  ext_sel = 1'b0; end
               OP_SLTI: alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         S_BR:    alu_control = ALU_SUB;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: Moore decode of the registered state plus the
// fetch handshake, driving every datapath select, enable and memory strobe.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input logic       clk,
   input logic       rst,
   mc_ctrl_if.master bus
);

   state_e     state_q, state_d;
   ctrl_t      ctrl_s, ctrl_out_s;
   logic [2:0] dec_alu_s;
   logic       dec_ext_s;
   logic       dec_illegal_s;

   alu_op_decoder u_alu_op_decoder (
      .state         (state_q),
      .opcode        (bus.opcode),
      .funct         (bus.funct),
      .alu_control   (dec_alu_s),
      .ext_sel       (dec_ext_s),
      .illegal_funct (dec_illegal_s)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IF;
      else      state_q <= state_d;
   end

   // Next-state and control-word decode.
   always_comb begin
      state_d = state_q;
      ctrl_s  = ctrl_default();
      case (state_q)
         S_IF: begin
            ctrl_s.mem_read  = 1'b1;
            ctrl_s.iord      = ADDR_PC;
            ctrl_s.alu_src_a = SRCA_PC;
            ctrl_s.alu_src_b = SRCB_FOUR;
            ctrl_s.pc_source = PCSRC_ALU;
            if (bus.mem_ready) begin
               ctrl_s.ir_write = 1'b1;
               ctrl_s.pc_write = 1'b1;
               state_d         = S_ID;
            end else begin
               state_d = S_IF;
            end
         end
         S_ID: begin
            ctrl_s.alu_src_a = SRCA_PC;
            ctrl_s.alu_src_b = SRCB_IMM_SH;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_RTYPE: begin
                  if (bus.funct == FN_JR) state_d = S_JR;
                  else                    state_d = S_R_EX;
               end
               OP_BEQ, OP_BNE:                    state_d = S_BR;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EX;
               OP_LUI:                            state_d = S_LUI_WB;
               OP_J:                              state_d = S_J;
               OP_JAL:                            state_d = S_JAL;
               default: begin
                  ctrl_s.illegal = 1'b1;
                  state_d        = S_IF;
               end
            endcase
         end
         S_MEM_ADR: begin
            ctrl_s.alu_src_a = SRCA_RS;
            ctrl_s.alu_src_b = SRCB_IMM;
            if (bus.opcode == OP_LW) state_d = S_MEM_RD;
            else                     state_d = S_MEM_WR;
         end
         S_MEM_RD: begin
            ctrl_s.mem_read = 1'b1;
            ctrl_s.iord     = ADDR_ALUO;
            if (bus.mem_ready) state_d = S_LW_WB;
            else               state_d = S_MEM_RD;
         end
         S_LW_WB: begin
            ctrl_s.reg_write   = 1'b1;
            ctrl_s.data_to_reg = WB_MDR;
            state_d            = S_IF;
         end
         S_MEM_WR: begin
            ctrl_s.mem_write = 1'b1;
            ctrl_s.iord      = ADDR_ALUO;
            if (bus.mem_ready) state_d = S_IF;
            else               state_d = S_MEM_WR;
         end
         S_R_EX: begin
            ctrl_s.alu_src_a   = SRCA_RS;
            ctrl_s.alu_src_b   = SRCB_RT;
            ctrl_s.alu_control = dec_alu_s;
            if (dec_illegal_s) begin
               ctrl_s.illegal = 1'b1;
               state_d        = S_IF;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_R_WB: begin
            ctrl_s.reg_write   = 1'b1;
            ctrl_s.reg_dst     = 1'b1;
            ctrl_s.data_to_reg = WB_ALUOUT;
            state_d            = S_IF;
         end
         S_I_EX: begin
            ctrl_s.alu_src_a   = SRCA_RS;
            ctrl_s.alu_src_b   = SRCB_IMM;
            ctrl_s.alu_control = dec_alu_s;
            ctrl_s.ext_sel     = dec_ext_s;
            state_d            = S_I_WB;
         end
         S_I_WB: begin
            ctrl_s.reg_write   = 1'b1;
            ctrl_s.data_to_reg = WB_ALUOUT;
            state_d            = S_IF;
         end
         S_BR: begin
            // ALUOut holds the branch target computed during ID.
            ctrl_s.alu_src_a   = SRCA_RS;
            ctrl_s.alu_src_b   = SRCB_RT;
            ctrl_s.alu_control = dec_alu_s;
            ctrl_s.pc_source   = PCSRC_ALUOUT;
            if (bus.opcode == OP_BNE) ctrl_s.pc_write = ~bus.zero;
            else                      ctrl_s.pc_write = bus.zero;
            state_d = S_IF;
         end
         S_J: begin
            ctrl_s.pc_source = PCSRC_JUMP;
            ctrl_s.pc_write  = 1'b1;
            state_d          = S_IF;
         end
         S_JAL: begin
            ctrl_s.pc_source   = PCSRC_JUMP;
            ctrl_s.pc_write    = 1'b1;
            ctrl_s.reg_write   = 1'b1;
            ctrl_s.jal         = 1'b1;
            ctrl_s.data_to_reg = WB_PC;
            state_d            = S_IF;
         end
         S_JR: begin
            ctrl_s.pc_source = PCSRC_RS;
            ctrl_s.pc_write  = 1'b1;
            state_d          = S_IF;
         end
         S_LUI_WB: begin
            ctrl_s.reg_write   = 1'b1;
            ctrl_s.data_to_reg = WB_LUI;
            state_d            = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // While reset is held every control is forced to its idle value.
   always_comb begin
      ctrl_out_s = ctrl_default();
      if (!rst) ctrl_out_s = ctrl_default();
      else      ctrl_out_s = ctrl_s;
   end

   assign bus.MemRead     = ctrl_out_s.mem_read;
   assign bus.MemWrite    = ctrl_out_s.mem_write;
   assign bus.IorD        = ctrl_out_s.iord;
   assign bus.IRWrite     = ctrl_out_s.ir_write;
   assign bus.PCWrite     = ctrl_out_s.pc_write;
   assign bus.PCSource    = ctrl_out_s.pc_source;
   assign bus.ALUSrcA     = ctrl_out_s.alu_src_a;
   assign bus.ALUSrc_B    = ctrl_out_s.alu_src_b;
   assign bus.ExtSel      = ctrl_out_s.ext_sel;
   assign bus.ALU_Control = ctrl_out_s.alu_control;
   assign bus.DatatoReg   = ctrl_out_s.data_to_reg;
   assign bus.RegDst      = ctrl_out_s.reg_dst;
   assign bus.Jal         = ctrl_out_s.jal;
   assign bus.RegWrite    = ctrl_out_s.reg_write;
   assign bus.illegal     = ctrl_out_s.illegal;
   assign bus.state       = rst ? state_q : S_IF;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit that sequences the team's MIPS datapath: one ALU and one unified memory port are shared across the IF/ID/EX/MEM/WB steps of each instruction. The block is a Moore-style FSM with a memory ready handshake. It decodes opcode/funct and drives every mux select, register write enable, memory strobe and PC update of the multi-cycle datapath. It sits beside the datapath in the CPU top and replaces the combinational single-cycle decoder.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- opcode  in  6  instruction-register bits [31:26], stable from the cycle after IF completes.
- funct  in  6  instruction-register bits [5:0].
- zero  in  1  ALU zero flag, used in BR.
- mem_ready  in  1  memory completed the current read/write this cycle.
- MemRead, MemWrite  out  1  memory strobes; held until mem_ready.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  PC load enable; includes the branch condition.
- PCSource  out  2  next-PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrc_B  out  2  ALU B input: 00 rt, 01 constant 4, 10 imm32, 11 imm32<<2.
- ExtSel  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- ALU_Control  out  3  ALU op: 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- DatatoReg  out  2  write-back source: 00 ALUOut, 01 MDR, 10 LUI value, 11 PC.
- RegDst  out  1  destination: 1 = rd, 0 = rt.
- Jal  out  1  force destination register $31.
- RegWrite  out  1  register-file write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- state  out  4  current state, for debug.

## Operation
- Supported instructions: R-type add/sub/and/or/xor/nor/slt/srl/jr; lw, sw, beq, bne, addi, andi, ori, slti, lui, j, jal.
- Default output in every state: 0, except ALU_Control = 010 and ExtSel = 1.
- **IF**: MemRead=1, IorD=0, ALUSrcA=0, ALUSrc_B=01, PCSource=00.
  - If mem_ready=1: IRWrite=1, PCWrite=1, next state ID.
  - Otherwise stay in IF; IRWrite=0 and PCWrite=0.
- **ID**: ALUSrcA=0, ALUSrc_B=11, ALUOut latches the branch target. Dispatch on opcode:
  - lw/sw → MEM_ADR
  - R-type, funct≠jr → R_EX
  - jr → JR
  - beq/bne → BR
  - addi/andi/ori/slti → I_EX
  - lui → LUI_WB
  - j → J
  - jal → JAL
  - anything else → IF, with illegal=1
- **MEM_ADR**: ALUSrcA=1, ALUSrc_B=10, add. Next: lw → MEM_RD, sw → MEM_WR.
- **MEM_RD**: MemRead=1, IorD=1; wait for mem_ready, then LW_WB.
- **LW_WB**: RegWrite=1, DatatoReg=01, RegDst=0 → IF.
- **MEM_WR**: MemWrite=1, IorD=1; wait for mem_ready, then IF.
- **R_EX**: ALUSrcA=1, ALUSrc_B=00, ALU_Control from funct → R_WB. Unknown funct → IF, with illegal=1.
- **R_WB**: RegWrite=1, RegDst=1, DatatoReg=00 → IF.
- **I_EX**: ALUSrcA=1, ALUSrc_B=10.
  - addi: add, ExtSel=1
  - andi: and, ExtSel=0
  - ori: or, ExtSel=0
  - slti: slt, ExtSel=1
  - Next state I_WB.
- **I_WB**: RegWrite=1, RegDst=0, DatatoReg=00 → IF.
- **BR**: ALUSrcA=1, ALUSrc_B=00, sub, PCSource=01.
  - PCWrite = zero for beq, ~zero for bne.
  - Next state IF.
- **J**: PCSource=10, PCWrite=1 → IF.
- **JAL**: PCSource=10, PCWrite=1, RegWrite=1, Jal=1, DatatoReg=11 → IF. The PC written to $31 is the PC+4 value latched in IF.
- **JR**: PCSource=11, PCWrite=1 → IF.
- **LUI_WB**: RegWrite=1, RegDst=0, DatatoReg=10 → IF.

## Timing
- Reset: rst=0 at a clock edge forces state = IF, from any state including mid-wait. During the reset cycle all outputs are 0, except ALU_Control=010 and ExtSel=1.
- The first fetch begins in the first cycle with rst=1.
- Outputs are a decode of the registered state, plus opcode/funct/zero where noted. No output depends combinationally on mem_ready, except IRWrite/PCWrite in IF.
- Cycle counts with mem_ready=1 on first request:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq/bne, j, jal, jr, lui: 3
- Each cycle of mem_ready=0 adds one cycle in IF, MEM_RD or MEM_WR.
- Memory handshake:
  - The strobe and address select stay stable while waiting.
  - mem_ready is ignored outside IF, MEM_RD and MEM_WR.
  - mem_ready is sampled in the same cycle as the strobe; no pipelined response.
- Illegal opcode: 2 cycles (IF, ID); the PC has already advanced by 4.
- Encoding 4'hF is unreachable; if entered, next state is IF.

## Structure
- Package mc_ctrl_pkg holds:
  - state encodings: IF=0, ID=1, MEM_ADR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BR=8, J=9, JAL=10, I_EX=11, I_WB=12, LUI_WB=13, JR=14
  - opcode and funct constants
  - ALU_Control codes
  - mux select codes
- Sub-module alu_op_decoder: combinational mapping of (state, opcode, funct) to ALU_Control, ExtSel and an illegal-funct flag. The FSM instantiates it once.

## Test plan
- Reset mid-MEM_RD (rst=0 for 1 cycle) → state=IF next cycle; MemRead=0 and RegWrite=0 during the reset cycle.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4; RegWrite=1 only in state 4, with DatatoReg=01.
- lw with mem_ready low for 3 cycles in MEM_RD → MemRead=1 and IorD=1 held for 4 cycles; total 8 cycles.
- beq with zero=1 → PCWrite=1, PCSource=01 in BR. bne with zero=1 → PCWrite=0 in BR.
- R-type funct 100111 (nor) → ALU_Control=100 in R_EX, RegDst=1 in R_WB. funct 000000 (unsupported sll) → illegal=1, return to IF.
- jal → state 10 with PCSource=10, Jal=1, DatatoReg=11, RegWrite=1. Opcode 111111 → illegal pulse in ID, back to IF.
